// File: rtl/feeder_pkg.sv
// feeder_pkg: shared constants and state encoding for the systolic_feeder slice.
//   DIM    - matrix dimension (fixed 4x4 array edge)
//   N_WAVE - number of skewed wavefronts per run (2*DIM-1)
//   K_W    - width of the wavefront counter k
//   IDX_W  - width of a row/column index inside one matrix
//   feeder_state_e - sequencer states; CLR is only reachable when the
//                    FEEDER_CLR_EN build option is defined.
package feeder_pkg;
  localparam int DIM    = 4;
  localparam int N_WAVE = 2 * DIM - 1;
  localparam int K_W    = 3;
  localparam int IDX_W  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } feeder_state_e;
endpackage

// File: rtl/feeder_skew_sel.sv
// feeder_skew_sel: combinational activation pick for one output lane.
// Lane LANE carries row LANE of A delayed by LANE cycles, so at wavefront k
// it shows A[LANE][k-LANE] inside the band 0..DIM-1 and zero outside it.
// Ports:
//   row - the DIM elements of A row LANE (element c at index c)
//   k   - current wavefront number
//   sel - selected element, or zero outside the band
module feeder_skew_sel
  import feeder_pkg::*;
#(
  parameter int DW   = 8,
  parameter int LANE = 0
) (
  input  logic [DIM-1:0][DW-1:0] row,
  input  logic [K_W-1:0]         k,
  output logic [DW-1:0]          sel
);

  int off;

  always_comb begin
    // Signed offset so lanes above 0 can see k < LANE as "not yet started".
    off = int'(k) - LANE;
    sel = '0;
    if ((off >= 0) && (off < DIM)) begin
      sel = row[off[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: input-edge sequencer for the 4x4 MAC array.
// Holds feature matrix A and weight matrix W; on start streams N_WAVE
// diagonally skewed activation wavefronts plus column-wise weight loads,
// then FLUSH_CYCLES all-zero cycles, then a one-cycle done pulse.
// Build option: FEEDER_CLR_EN adds the array_clr port and a CLR state that
// precedes STREAM, delaying every later output by one cycle.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data - element write (sel 0=A, 1=W; addr=row*4+col),
//                           accepted only in IDLE, otherwise dropped with wr_err
//   start                 - begin a run, sampled only in IDLE
//   a_lane0..3            - skewed activations to array inputs a11..a14
//   w_lane0..3, w_col_strobe - weight column k for array rows 1..4, one-hot strobe
//   carry_in              - partial-sum seed, always zero
//   busy, done, wr_err    - status (done and wr_err are one-cycle pulses)
//   array_clr             - (FEEDER_CLR_EN only) one-cycle array clear
//   state_dbg             - current sequencer state
// All status and lane outputs are registered: outputs after edge e reflect
// the state held between edges e-1 and e.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int DW           = 8,
  parameter int ACC_W        = 24,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [3:0]       wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  output logic [DW-1:0]    a_lane0,
  output logic [DW-1:0]    a_lane1,
  output logic [DW-1:0]    a_lane2,
  output logic [DW-1:0]    a_lane3,
  output logic [DW-1:0]    w_lane0,
  output logic [DW-1:0]    w_lane1,
  output logic [DW-1:0]    w_lane2,
  output logic [DW-1:0]    w_lane3,
  output logic [3:0]       w_col_strobe,
  output logic [ACC_W-1:0] carry_in,
  output logic             busy,
  output logic             done,
  output logic             wr_err,
`ifdef FEEDER_CLR_EN
  output logic             array_clr,
`endif
  output feeder_state_e    state_dbg
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST =
    (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

  logic [DIM-1:0][DIM-1:0][DW-1:0] mat_a, mat_w;  // [row][col]

  feeder_state_e          state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [FC_W-1:0]        fc_q, fc_d;

  logic [DIM-1:0][DW-1:0] skew;
  logic [DIM-1:0][DW-1:0] a_d, a_q, w_d, w_q;
  logic [DIM-1:0]         strobe_d, strobe_q;
  logic                   busy_d, busy_q, done_d, done_q, wr_err_q;
`ifdef FEEDER_CLR_EN
  logic                   clr_d, clr_q;
`endif

  for (genvar j = 0; j < DIM; j++) begin : g_skew
    feeder_skew_sel #(.DW(DW), .LANE(j)) u_sel (
      .row (mat_a[j]),
      .k   (k_q),
      .sel (skew[j])
    );
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    fc_d     = fc_q;
    a_d      = '0;
    w_d      = '0;
    strobe_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef FEEDER_CLR_EN
    clr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d = '0;
`ifdef FEEDER_CLR_EN
          state_d = CLR;
`else
          state_d = STREAM;
`endif
        end
      end
      CLR: begin
`ifdef FEEDER_CLR_EN
        clr_d = 1'b1;
`endif
        k_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        busy_d = 1'b1;
        a_d    = skew;
        if (k_q < K_W'(DIM)) begin
          strobe_d = DIM'(1) << k_q[IDX_W-1:0];
          for (int i = 0; i < DIM; i++) begin
            w_d[i] = mat_w[i][k_q[IDX_W-1:0]];
          end
        end
        if (k_q == K_W'(N_WAVE - 1)) begin
          k_d     = '0;
          fc_d    = '0;
          state_d = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      FLUSH: begin
        busy_d = 1'b1;
        if (fc_q == FC_LAST) begin
          state_d = DONE;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fc_q    <= fc_d;
    end
  end

  // Output registers and matrix storage. A write in the same cycle as an
  // accepted start lands before the first wavefront is selected.
  always_ff @(posedge clock) begin
    if (reset) begin
      mat_a    <= '0;
      mat_w    <= '0;
      a_q      <= '0;
      w_q      <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
`ifdef FEEDER_CLR_EN
      clr_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      w_q      <= w_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= 1'b0;
`ifdef FEEDER_CLR_EN
      clr_q    <= clr_d;
`endif
      if (wr_en) begin
        if (state_q == IDLE) begin
          if (wr_sel) begin
            mat_w[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
          end else begin
            mat_a[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
          end
        end else begin
          wr_err_q <= 1'b1;
        end
      end
    end
  end

  assign a_lane0      = a_q[0];
  assign a_lane1      = a_q[1];
  assign a_lane2      = a_q[2];
  assign a_lane3      = a_q[3];
  assign w_lane0      = w_q[0];
  assign w_lane1      = w_q[1];
  assign w_lane2      = w_q[2];
  assign w_lane3      = w_q[3];
  assign w_col_strobe = strobe_q;
  assign carry_in     = '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_err       = wr_err_q;
`ifdef FEEDER_CLR_EN
  assign array_clr    = clr_q;
`endif
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder.
// The driver pushes the expected output records of each accepted run into
// exp_q (computed from matrix models ma/mw); the negedge monitor pops one
// record every cycle the DUT shows busy or done and compares.
`timescale 1ns/1ps
module tb_systolic_feeder;
  import feeder_pkg::*;

  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int FC    = 3;
`ifdef FEEDER_CLR_EN
  localparam int CLR_X = 1;
`else
  localparam int CLR_X = 0;
`endif
  localparam int RUN_LAT = 8 + FC + CLR_X;  // start edge to done edge
  localparam int PERIOD  = 9 + FC + CLR_X;  // back-to-back run period
  localparam int REC_W   = 1 + DIM + 2 * DIM * DW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [3:0]       wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [DW-1:0]    a_lane0, a_lane1, a_lane2, a_lane3;
  logic [DW-1:0]    w_lane0, w_lane1, w_lane2, w_lane3;
  logic [3:0]       w_col_strobe;
  logic [ACC_W-1:0] carry_in;
  logic             busy, done, wr_err;
`ifdef FEEDER_CLR_EN
  logic             array_clr;
`endif
  feeder_state_e    state_dbg;

  systolic_feeder #(.DW(DW), .ACC_W(ACC_W), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .a_lane0(a_lane0), .a_lane1(a_lane1), .a_lane2(a_lane2), .a_lane3(a_lane3),
    .w_lane0(w_lane0), .w_lane1(w_lane1), .w_lane2(w_lane2), .w_lane3(w_lane3),
    .w_col_strobe(w_col_strobe), .carry_in(carry_in), .busy(busy), .done(done),
    .wr_err(wr_err),
`ifdef FEEDER_CLR_EN
    .array_clr(array_clr),
`endif
    .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- model / scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [REC_W-1:0] exp_q[$];
  int done_cyc_q[$];
  int last_start = -100;
  logic [DW-1:0] ma[DIM][DIM];
  logic [DW-1:0] mw[DIM][DIM];

  task automatic check(input string name, input logic [REC_W-1:0] act,
                       input logic [REC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Output bundle for wavefront k: lane j carries row j delayed by j cycles,
  // weights carry column k for the first DIM wavefronts.
  function automatic logic [REC_W-1:0] wave_rec(input int k);
    logic [DIM-1:0][DW-1:0] a, w;
    logic [DIM-1:0] s;
    a = '0; w = '0; s = '0;
    for (int j = 0; j < DIM; j++)
      if (k - j >= 0 && k - j < DIM) a[j] = ma[j][k - j];
    if (k < DIM) begin
      s[k] = 1'b1;
      for (int i = 0; i < DIM; i++) w[i] = mw[i][k];
    end
    return {1'b0, s, w, a};
  endfunction

  // n_wave < 0: full run (all wavefronts, flush zeros, done); else only the
  // first n_wave wavefronts (run aborted by reset).
  task automatic push_run(input int n_wave, input int t);
    logic [REC_W-1:0] done_rec;
    if (n_wave < 0) begin
      for (int k = 0; k < N_WAVE; k++) exp_q.push_back(wave_rec(k));
      for (int f = 0; f < FC; f++) exp_q.push_back('0);
      done_rec = '0;
      done_rec[REC_W-1] = 1'b1;
      exp_q.push_back(done_rec);
      done_cyc_q.push_back(t + RUN_LAT);
    end else begin
      for (int k = 0; k < n_wave; k++) exp_q.push_back(wave_rec(k));
    end
  endtask

  // ---------------- monitor ----------------
  logic [REC_W-1:0] mon_act, mon_exp;
  int mon_d;
  always @(negedge clock) begin
    if (cyc > 0) begin
      mon_act = {done, w_col_strobe, w_lane3, w_lane2, w_lane1, w_lane0,
                 a_lane3, a_lane2, a_lane1, a_lane0};
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output at cycle %0d: got %h, expected no activity",
                   cyc, mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check("lanes", mon_act, mon_exp);
          check("busy", REC_W'(busy), REC_W'(!mon_exp[REC_W-1]));
          if (mon_exp[REC_W-1]) begin
            if (done_cyc_q.size() > 0) begin
              mon_d = done_cyc_q.pop_front();
              check("done_cycle", REC_W'(cyc), REC_W'(mon_d));
            end else begin
              n_checks++;
              n_fail++;
              $display("FAIL done_cycle at cycle %0d: got done, expected no done", cyc);
            end
          end
        end
      end else begin
        check("idle_lanes", mon_act, '0);
      end
      check("carry_in", REC_W'(carry_in), '0);
`ifdef FEEDER_CLR_EN
      if (array_clr) check("clr_cycle", REC_W'(cyc), REC_W'(last_start + 1));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs (from posedge+1), waits for the sampling edge.
  task automatic step(input logic st, input logic acc, input int n_wave,
                      input logic we, input logic ws, input logic [3:0] wa,
                      input logic [DW-1:0] wd, input logic err);
    start = st; wr_en = we; wr_sel = ws; wr_addr = wa; wr_data = wd;
    @(posedge clock); #1;
    if (we) begin
      check("wr_err", REC_W'(wr_err), REC_W'(err));
      if (!err) begin
        if (ws) mw[wa[3:2]][wa[1:0]] = wd;
        else    ma[wa[3:2]][wa[1:0]] = wd;
      end
    end
    if (st && acc) begin
      last_start = cyc;
      push_run(n_wave, cyc);
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, '0, 1'b0);
  endtask

  task automatic write(input logic ws, input logic [3:0] wa, input logic [DW-1:0] wd);
    step(1'b0, 1'b0, 0, 1'b1, ws, wa, wd, 1'b0);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clock); #1;
      b++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d records pending, expected 0", exp_q.size());
      exp_q.delete();
      done_cyc_q.delete();
    end
  endtask

  task automatic run();
    step(1'b1, 1'b1, -1, 1'b0, 1'b0, 4'h0, '0, 1'b0);
    drain();
  endtask

  task automatic clear_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = '0;
        mw[r][c] = '0;
      end
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] a_rows[DIM][DIM];
  initial begin
    a_rows = '{'{8'd4, 8'd0, 8'd2, 8'd1}, '{8'd4, 8'd3, 8'd2, 8'd0},
               '{8'd4, 8'd3, 8'd0, 8'd1}, '{8'd4, 8'd3, 8'd2, 8'd1}};
    clear_model();
    repeat (3) @(posedge clock);
    #1;
    // Reset values
    check("rst_a_lanes", REC_W'({a_lane3, a_lane2, a_lane1, a_lane0}), '0);
    check("rst_w_lanes", REC_W'({w_lane3, w_lane2, w_lane1, w_lane0}), '0);
    check("rst_strobe", REC_W'(w_col_strobe), '0);
    check("rst_status", REC_W'({busy, done, wr_err}), '0);
    reset = 1'b0;
    idle(1);

    // Reference matrices, single run
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        write(1'b0, 4'(r * 4 + c), a_rows[r][c]);
        write(1'b1, 4'(r * 4 + c), DW'(c + 1));
      end
    run();

    // Writes during a run are dropped; a second run is identical
    step(1'b1, 1'b1, -1, 1'b0, 1'b0, 4'h0, '0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 4'h5, 8'hEE, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 4'hA, 8'h77, 1'b1);
    drain();
    run();

    // Reset while wavefront 3 is on the outputs
    step(1'b1, 1'b1, 4, 1'b0, 1'b0, 4'h0, '0, 1'b0);
    idle(4 + CLR_X);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_lanes", REC_W'({w_col_strobe, w_lane3, w_lane2, w_lane1, w_lane0,
                                 a_lane3, a_lane2, a_lane1, a_lane0}), '0);
    check("abort_status", REC_W'({busy, done, wr_err}), '0);
    check("abort_queue", REC_W'(exp_q.size()), '0);
    clear_model();
    idle(2);
    run();

    // Random matrices, start held high: runs repeat every PERIOD cycles
    for (int i = 0; i < 32; i++)
      write(1'($urandom_range(0, 1)), 4'(i % 16), DW'($urandom_range(0, 255)));
    for (int i = 0; i < 3 * PERIOD; i++)
      step(1'b1, (i % PERIOD) == 0, -1, 1'b0, 1'b0, 4'h0, '0, 1'b0);
    drain();

    // Write in the same cycle as start is visible to the run
    step(1'b1, 1'b1, -1, 1'b1, 1'b0, 4'h0, 8'd9, 1'b0);
    drain();

    // Random updates followed by runs
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 6; n++)
        write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              DW'($urandom_range(0, 255)));
      run();
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Sequencer that drives the 4x4 MAC array's input edge. It holds a 4x4 feature matrix A and a 4x4 weight matrix W in local register files and, on `start`, emits diagonally skewed activation wavefronts on four lanes together with column-wise weight loads. It then flushes with zeros and pulses `done`. It sits between the memory/host load path and the MAC array, replacing hand-sequenced stimulus.

## Interface
- `DIM`, 4 — matrix dimension; fixed at 4 (package constant).
- `DW`, 8 — activation/weight width.
- `ACC_W`, 24 — width of array `carry_in`.
- `FLUSH_CYCLES`, 3 — all-zero cycles after the last wavefront.
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `wr_en` in 1 — matrix write strobe.
- `wr_sel` in 1 — 0 = feature A, 1 = weight W.
- `wr_addr` in 4 — row*4+col.
- `wr_data` in DW — element value.
- `start` in 1 — begin a run; sampled only in IDLE.
- `a_lane0..a_lane3` out DW each — skewed activations, to array inputs a11..a14.
- `w_lane0..w_lane3` out DW each — weight column data for array rows 1..4.
- `w_col_strobe` out 4 — one-hot; bit k means the w_lanes carry column k.
- `carry_in` out ACC_W — constant 0 during a run.
- `busy` out 1 — high in STREAM and FLUSH.
- `done` out 1 — one-cycle pulse at end of run.
- `wr_err` out 1 — one-cycle pulse when a write is dropped because `busy` is high.
- `array_clr` out 1 — present only with `FEEDER_CLR_EN`.

## Operation
- States: IDLE → (CLR) → STREAM → FLUSH → DONE → IDLE.
- IDLE:
  - `wr_en` writes `wr_data` to A or W at `wr_addr`.
  - `start` moves to STREAM, or to CLR when that is configured.
  - A write in the same cycle as `start` is performed and is visible to the run.
- STREAM: wavefront counter k runs 0..6, one per cycle (7 cycles).
  - `a_laneJ` = A[J][k−J] if 0 ≤ k−J ≤ 3, otherwise 0.
  - For k ≤ 3: `w_col_strobe` = 1<<k and `w_laneI` = W[I][k].
  - For k ≥ 4: `w_col_strobe` = 0 and the w_lanes are 0.
- FLUSH: all lanes 0 and strobe 0 for FLUSH_CYCLES cycles. FLUSH_CYCLES = 0 skips directly to DONE.
- DONE: `done` = 1 for one cycle, lanes 0, `busy` = 0. Returns to IDLE.
- `start` while busy or in DONE is ignored and not queued.
- `wr_en` while busy: the write is dropped, `wr_err` pulses, and the matrices are unchanged.
- Arithmetic: the feeder does pass-through only. Values are unsigned DW bits and are never widened.

## Timing
- All outputs are registered.
- Reset values: all lanes 0, `w_col_strobe` 0, `carry_in` 0, `busy` 0, `done` 0, `wr_err` 0, `array_clr` 0, state IDLE. Matrices reset to 0.
- `reset` mid-run aborts on the next edge to the reset values, with no `done` pulse. Matrix contents are cleared.
- `start` sampled at edge t gives:
  - wavefront k at the outputs after edge t+1+k;
  - `busy` high from t+1 through t+7+FLUSH_CYCLES;
  - `done` after edge t+8+FLUSH_CYCLES.
- Back-to-back runs: `start` accepted in the first IDLE cycle after `done`. Minimum run period is 9+FLUSH_CYCLES cycles.

## Configuration
- `FEEDER_CLR_EN` defined:
  - adds port `array_clr`;
  - inserts state CLR, with `array_clr` = 1 for one cycle after edge t+1;
  - every STREAM/FLUSH/DONE timing above shifts by +1 cycle.
- `FEEDER_CLR_EN` undefined: port and state are absent, and timing is as stated above.

## Structure
- Package `feeder_pkg`:
  - constants `DIM`=4 and `N_WAVE`=2*DIM−1=7;
  - the state enum (IDLE, CLR, STREAM, FLUSH, DONE);
  - the counter width for k (3 bits).
- Sub-module `feeder_skew_sel`: combinational selection of A[J][k−J] with zero outside the band, one instance per lane. The top-level FSM registers its outputs.

## Test plan
- Load A rows {4,0,2,1},{4,3,2,0},{4,3,0,1},{4,3,2,1} and W rows all {1,2,3,4}, then pulse `start`. Required outputs:
  - wavefront k=0: lanes (4,0,0,0);
  - k=3: lanes (1,2,3,4);
  - k=6: lanes (0,0,0,1);
  - k=2: `w_col_strobe`=0100 and all w_lanes = 3;
  - `done` 11 cycles after `start`.
- Write during `busy` → `wr_err` pulses, and a second run produces identical lanes.
- Assert `reset` at wavefront k=3 → all outputs 0 on the next edge, no `done`, matrices read back 0 on the next run.
- `start` held high continuously → runs repeat every 12 cycles, with one IDLE cycle between runs.
- Write A[0][0]=9 in the same cycle as `start` → wavefront 0 shows lane0 = 9.
- With `FEEDER_CLR_EN`: `array_clr` pulses one cycle after `start`, and wavefront 0 appears one cycle later than without it.
